// File: rtl/box_drawer.sv
// Redraws the player box on the 160x120 framebuffer each frame tick:
// erase at the previous row (if any), draw at the new row, one pixel per clock.
module box_drawer #(
    parameter logic [7:0] BOX_X      = 8'd40,
    parameter int         BOX_SIZE   = 4,
    parameter logic [2:0] BOX_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR  = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [6:0] y_coordinate,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ERASE  = 2'd1;
    localparam logic [1:0] S_DRAW   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [2:0] LAST = 3'(BOX_SIZE - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;
    logic [6:0] new_y_q, new_y_d;
    logic [6:0] old_y_q, old_y_d;
    logic       old_valid_q, old_valid_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [6:0] base_y;
    logic [7:0] row_sum;
    logic       last_px;

    // 8-bit sum so rows past 127 cannot alias back onto the visible area
    assign base_y  = (state_q == S_ERASE) ? old_y_q : new_y_q;
    assign row_sum = {1'b0, base_y} + {5'd0, row_q};
    assign last_px = (col_q == LAST) && (row_q == LAST);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        new_y_d     = new_y_q;
        old_y_d     = old_y_q;
        old_valid_d = old_valid_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        plot_d      = 1'b0;
        busy_d      = (state_q != S_IDLE);
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    new_y_d = y_coordinate;
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                    state_d = old_valid_q ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                x_d      = BOX_X + {5'd0, col_q};
                y_d      = row_sum[6:0];
                colour_d = (state_q == S_ERASE) ? BG_COLOUR : BOX_COLOUR;
                plot_d   = (row_sum <= 8'd119);
                if (last_px) begin
                    col_d   = 3'd0;
                    row_d   = 3'd0;
                    state_d = (state_q == S_ERASE) ? S_DRAW : S_FINISH;
                end else if (col_q == LAST) begin
                    col_d = 3'd0;
                    row_d = row_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            S_FINISH: begin
                done_d      = 1'b1;
                old_y_d     = new_y_q;
                old_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            col_q       <= 3'd0;
            row_q       <= 3'd0;
            new_y_q     <= 7'd0;
            old_y_q     <= 7'd0;
            old_valid_q <= 1'b0;
            x_q         <= 8'd0;
            y_q         <= 7'd0;
            colour_q    <= 3'd0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            new_y_q     <= new_y_d;
            old_y_q     <= old_y_d;
            old_valid_q <= old_valid_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
